// File: rtl/secded_dec_pipe.sv
// secded_dec_pipe: two-stage SECDED decoder with valid/ready flow control,
// saturating error counters and a last-nonzero-syndrome register.
module secded_dec_pipe #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 7,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W+CHK_W-1:0] IN,
  input  logic                    corr_en,
  input  logic                    cnt_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       OUT,
  output logic [CHK_W-1:0]        SYNn,
  output logic                    sec,
  output logic                    ded,
  output logic                    chk_err,
  output logic [CNT_W-1:0]        cnt_sec,
  output logic [CNT_W-1:0]        cnt_ded,
  output logic [CHK_W-1:0]        last_syn
);
  // i-th CHK_W-bit value of odd weight >= 3, ascending
  function automatic logic [CHK_W-1:0] col(input int i);
    int n;
    int w;
    logic [CHK_W-1:0] r;
    n = 0;
    r = '0;
    for (int v = 0; v < 2**CHK_W; v++) begin
      w = 0;
      for (int b = 0; b < CHK_W; b++) w += (v >> b) & 1;
      if (w >= 3 && w % 2 == 1) begin
        if (n == i) r = CHK_W'(v);
        n++;
      end
    end
    return r;
  endfunction

  logic [CHK_W-1:0] cols [DATA_W];
  for (genvar i = 0; i < DATA_W; i++) begin : g_col
    assign cols[i] = col(i);
  end

  logic [CHK_W-1:0]  syn, syn1;
  logic [DATA_W-1:0] data1, flip;
  logic              v1, corr1, adv2, xfer, hit, one_hot;

  always_comb begin
    syn = IN[DATA_W +: CHK_W];
    for (int i = 0; i < DATA_W; i++) syn ^= IN[i] ? cols[i] : '0;
  end

  always_comb begin
    flip = '0;
    for (int i = 0; i < DATA_W; i++) flip[i] = cols[i] == syn1;
  end

  assign hit      = |flip;
  assign one_hot  = $onehot(syn1);
  assign adv2     = v1 && (!out_valid || out_ready);
  assign in_ready = !rst && (!v1 || adv2);
  assign xfer     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data1 <= IN[DATA_W-1:0];
      syn1  <= syn;
      corr1 <= corr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      OUT       <= '0;
      SYNn      <= '0;
      sec       <= 1'b0;
      ded       <= 1'b0;
      chk_err   <= 1'b0;
      cnt_sec   <= '0;
      cnt_ded   <= '0;
      last_syn  <= '0;
    end else begin
      v1        <= (in_valid && in_ready) || (v1 && !adv2);
      out_valid <= adv2 || (out_valid && !out_ready);
      if (adv2) begin
        OUT     <= corr1 && hit ? data1 ^ flip : data1;
        SYNn    <= syn1;
        sec     <= hit || one_hot;
        ded     <= syn1 != '0 && !hit && !one_hot;
        chk_err <= one_hot;
      end
      if (cnt_clr) cnt_sec <= '0;
      else if (xfer && sec && !(&cnt_sec)) cnt_sec <= cnt_sec + CNT_W'(1);
      if (cnt_clr) cnt_ded <= '0;
      else if (xfer && ded && !(&cnt_ded)) cnt_ded <= cnt_ded + CNT_W'(1);
      if (xfer && SYNn != '0) last_syn <= SYNn;
    end
  end
endmodule
